rv_alu1_bypass: RTL

Parametrised successor to the ALU stage-1 register: captures the decoded instruction under a valid/ready handshake, resolves rs1/rs2 through an N-channel priority bypass network, holds resolved operands across downstream stalls, and computes the jump/branch/mret target. It sits between decode and the ALU-2/branch-resolve stage. It replaces the unconditional capture-every-cycle register with backpressure-aware pipelining and hazard stalling.

---
 rtl/rv_alu1_bypass_pkg.sv | 43 ++++
 rtl/rv_alu1_fwd_mux.sv | 58 +++++
 rtl/rv_alu1_bypass.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv_alu1_bypass_pkg.sv
// Shared types for the ALU stage-1 bypass register (package rv_structs).
// Holds decode control enums, the operand-2 source selector and the
// per-channel forwarding record used by the bypass network.
package rv_structs;

  // Architectural x0: never forwarded, always read from the register file.
  localparam logic [4:0] RV_REG_ZERO = 5'd0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_res_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_CSR = 2'd3
  } res_src_t;

  // Operand-2 source: i selects imm_i, j selects imm_j, neither selects rs2.
  typedef struct packed {
    logic i;
    logic j;
  } src_op2_t;

  // One bypass channel as seen by the operand resolvers.
  typedef struct packed {
    logic        valid;
    logic        busy;
    logic [4:0]  rd;
    logic [31:0] data;
  } fwd_ch_t;

endpackage

// File: rtl/rv_alu1_fwd_mux.sv
// Single-operand resolver: priority match over the bypass channels
// (lowest index wins), falls back to register-file data, and freezes the
// resolved value in a hold register while the instruction is stalled.
module rv_alu1_fwd_mux
  import rv_structs::*;
#(
  parameter int FWD_CH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             rs,
  input  logic [31:0]            reg_data,
  input  fwd_ch_t [FWD_CH-1:0]   fwd,
  input  logic                   valid,
  input  logic                   capture,
  input  logic                   transfer,
  input  logic                   flush,
  output logic [31:0]            value,
  output logic                   ready
);

  logic        match_hit;
  logic        match_busy;
  logic [31:0] match_data;
  logic        hold_flag;
  logic [31:0] hold_reg;

  // Priority match: walk from the highest index down so channel 0 wins last.
  always_comb begin
    match_hit  = 1'b0;
    match_busy = 1'b0;
    match_data = reg_data;
    for (int c = FWD_CH - 1; c >= 0; c--) begin
      if (rs != RV_REG_ZERO && fwd[c].rd == rs && (fwd[c].valid || fwd[c].busy)) begin
        match_hit  = 1'b1;
        match_busy = fwd[c].busy;
        match_data = fwd[c].data;
      end
    end
  end

  assign value = hold_flag ? hold_reg : match_data;
  assign ready = hold_flag | !(match_hit & match_busy);

  // Freeze a ready value while stalled; any new instruction or flush releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_flag <= 1'b0;
      hold_reg  <= '0;
    end else if (flush || capture || transfer) begin
      hold_flag <= 1'b0;
    end else if (valid && ready && !hold_flag) begin
      hold_flag <= 1'b1;
      hold_reg  <= value;
    end
  end

endmodule

// File: rtl/rv_alu1_bypass.sv
// ALU stage-1 register with valid/ready handshake, N-channel operand
// bypass, stall-safe operand holding and jump/branch target computation.
// Optional macro RV_ALU1_MRET_EN enables the mret return-address target.
module rv_alu1_bypass
  import rv_structs::*;
#(
  parameter int IADDR_SPACE_BITS = 32,
  parameter int FWD_CH           = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_flush,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_valid,
  input  logic                        i_ready,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc_next,
  input  logic [IADDR_SPACE_BITS-1:0] i_ret_addr,
  input  logic [4:0]                  i_rs1,
  input  logic [4:0]                  i_rs2,
  input  logic [4:0]                  i_rd,
  input  logic [31:0]                 i_imm_i,
  input  logic [31:0]                 i_imm_j,
  input  alu_res_t                    i_alu_res,
  input  logic [2:0]                  i_funct3,
  input  logic [4:0]                  i_alu_sub,
  input  res_src_t                    i_res_src,
  input  logic                        i_op1_src,
  input  src_op2_t                    i_op2_src,
  input  logic                        i_reg_write,
  input  logic                        i_inst_mret,
  input  logic                        i_inst_jalr,
  input  logic                        i_inst_jal,
  input  logic                        i_inst_branch,
  input  logic                        i_inst_store,
  input  logic                        i_to_trap,
  input  logic                        i_branch_pred,
  input  logic [31:0]                 i_reg1_data,
  input  logic [31:0]                 i_reg2_data,
  input  logic [FWD_CH-1:0]           i_fwd_valid,
  input  logic [FWD_CH-1:0]           i_fwd_busy,
  input  logic [5*FWD_CH-1:0]         i_fwd_rd,
  input  logic [32*FWD_CH-1:0]        i_fwd_data,
  output logic [31:0]                 o_op1,
  output logic [31:0]                 o_op2,
  output logic [31:0]                 o_reg_data1,
  output logic [31:0]                 o_reg_data2,
  output logic [IADDR_SPACE_BITS-1:0] o_pc,
  output logic [IADDR_SPACE_BITS-1:0] o_pc_next,
  output logic [IADDR_SPACE_BITS-1:0] o_pc_target,
  output logic [4:0]                  o_rs1,
  output logic [4:0]                  o_rs2,
  output logic [4:0]                  o_rd,
  output alu_res_t                    o_res,
  output logic [2:0]                  o_funct3,
  output logic [4:0]                  o_alu_sub,
  output res_src_t                    o_res_src,
  output logic                        o_store,
  output logic                        o_reg_write,
  output logic                        o_inst_branch,
  output logic                        o_inst_jal_jalr,
  output logic                        o_to_trap,
  output logic                        o_branch_pred,
  output logic                        o_hazard
);

  localparam int A = IADDR_SPACE_BITS;

  logic           valid_r;
  logic           capture;
  logic           transfer;
  logic           rdy1;
  logic           rdy2;
  logic [31:0]    res1;
  logic [31:0]    res2;
  fwd_ch_t [FWD_CH-1:0] fwd;

  logic [31:0]    imm_i_r;
  logic [31:0]    imm_j_r;
  logic           op1_src_r;
  src_op2_t       op2_src_r;
  logic           jalr_r;
  logic [A-1:0]   target_calc;

  // Unpack the flat channel buses into per-channel records.
  generate
    for (genvar gi = 0; gi < FWD_CH; gi++) begin : g_fwd
      assign fwd[gi] = '{valid: i_fwd_valid[gi],
                         busy:  i_fwd_busy[gi],
                         rd:    i_fwd_rd[5*gi +: 5],
                         data:  i_fwd_data[32*gi +: 32]};
    end
  endgenerate

  assign capture  = i_valid & o_ready;
  assign transfer = o_valid & i_ready;
  assign o_ready  = !valid_r | transfer;
  assign o_valid  = valid_r & rdy1 & rdy2;
  assign o_hazard = valid_r & !(rdy1 & rdy2);

  rv_alu1_fwd_mux #(.FWD_CH(FWD_CH)) u_fwd1 (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .rs       (o_rs1),
    .reg_data (i_reg1_data),
    .fwd      (fwd),
    .valid    (valid_r),
    .capture  (capture),
    .transfer (transfer),
    .flush    (i_flush),
    .value    (res1),
    .ready    (rdy1)
  );

  rv_alu1_fwd_mux #(.FWD_CH(FWD_CH)) u_fwd2 (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .rs       (o_rs2),
    .reg_data (i_reg2_data),
    .fwd      (fwd),
    .valid    (valid_r),
    .capture  (capture),
    .transfer (transfer),
    .flush    (i_flush),
    .value    (res2),
    .ready    (rdy2)
  );

  // Occupancy: flush drops the instruction, capture refills, transfer drains.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)      valid_r <= 1'b0;
    else if (i_flush)    valid_r <= 1'b0;
    else if (capture)    valid_r <= 1'b1;
    else if (transfer)   valid_r <= 1'b0;
  end

  // Instruction fields load only on an accepted, unflushed capture.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pc            <= '0;
      o_pc_next       <= '0;
      o_rs1           <= '0;
      o_rs2           <= '0;
      o_rd            <= '0;
      imm_i_r         <= '0;
      imm_j_r         <= '0;
      o_res           <= ALU_ADD;
      o_funct3        <= '0;
      o_alu_sub       <= '0;
      o_res_src       <= RES_ALU;
      op1_src_r       <= 1'b0;
      op2_src_r       <= '0;
      o_reg_write     <= 1'b0;
      jalr_r          <= 1'b0;
      o_inst_jal_jalr <= 1'b0;
      o_inst_branch   <= 1'b0;
      o_store         <= 1'b0;
      o_to_trap       <= 1'b0;
      o_branch_pred   <= 1'b0;
    end else if (capture && !i_flush) begin
      o_pc            <= i_pc;
      o_pc_next       <= i_pc_next;
      o_rs1           <= i_rs1;
      o_rs2           <= i_rs2;
      o_rd            <= i_rd;
      imm_i_r         <= i_imm_i;
      imm_j_r         <= i_imm_j;
      o_res           <= i_alu_res;
      o_funct3        <= i_funct3;
      o_alu_sub       <= i_alu_sub;
      o_res_src       <= i_res_src;
      op1_src_r       <= i_op1_src;
      op2_src_r       <= i_op2_src;
      o_reg_write     <= i_reg_write;
      jalr_r          <= i_inst_jalr;
      o_inst_branch   <= i_inst_branch;
      o_store         <= i_inst_store;
      o_to_trap       <= i_to_trap;
      o_branch_pred   <= i_branch_pred;
`ifdef RV_ALU1_MRET_EN
      o_inst_jal_jalr <= i_inst_jal | i_inst_jalr | i_inst_mret;
`else
      o_inst_jal_jalr <= i_inst_jal | i_inst_jalr;
`endif
    end
  end

`ifdef RV_ALU1_MRET_EN
  logic         mret_r;
  logic [A-1:0] ret_addr_r;

  // Return-address path for mret, captured alongside the instruction.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mret_r     <= 1'b0;
      ret_addr_r <= '0;
    end else if (capture && !i_flush) begin
      mret_r     <= i_inst_mret;
      ret_addr_r <= i_ret_addr;
    end
  end
`else
  logic unused_mret;
  assign unused_mret = i_inst_mret ^ (^i_ret_addr);
`endif

  // Target select: mret return address, jalr rs1+imm_i, else pc+imm_j (wraps).
  always_comb begin
    target_calc = o_pc + imm_j_r[A-1:0];
    if (jalr_r) target_calc = res1[A-1:0] + imm_i_r[A-1:0];
`ifdef RV_ALU1_MRET_EN
    if (mret_r) target_calc = ret_addr_r;
`endif
  end

  // Datapath outputs read as zero whenever the stage is empty.
  always_comb begin
    o_reg_data1 = '0;
    o_reg_data2 = '0;
    o_op1       = '0;
    o_op2       = '0;
    o_pc_target = '0;
    if (valid_r) begin
      o_reg_data1 = res1;
      o_reg_data2 = res2;
      o_op1       = op1_src_r ? 32'(o_pc) : res1;
      o_op2       = op2_src_r.i ? imm_i_r : (op2_src_r.j ? imm_j_r : res2);
      o_pc_target = target_calc;
    end
  end

endmodule
